// File: rtl/conv_window_accumulator.sv
// Streaming KxK multi-channel convolution with runtime-loadable signed weights and a saturated result.
// Result lands on the 2nd enabled edge after pixel acceptance; one pixel per enabled cycle, no backpressure.
module conv_window_accumulator #(
    parameter int D_WIDTH     = 8,
    parameter int W_WIDTH     = 8,
    parameter int Q_WIDTH     = 16,
    parameter int D_CHANNELS  = 2,
    parameter int FILTER_SIZE = 2,
    parameter int IMAGE_SIZE  = 64
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  clk_en,
    input  logic                                                  in_valid,
    input  logic [D_CHANNELS*D_WIDTH-1:0]                         input_data,
    input  logic                                                  w_wr_en,
    input  logic [$clog2(D_CHANNELS*FILTER_SIZE*FILTER_SIZE)-1:0] w_addr,
    input  logic signed [W_WIDTH-1:0]                             w_data,
    output logic signed [Q_WIDTH-1:0]                             output_data,
    output logic                                                  valid,
    output logic                                                  last
);
    localparam int K      = FILTER_SIZE;
    localparam int N      = IMAGE_SIZE;
    localparam int NT     = D_CHANNELS * K * K;
    localparam int CW     = $clog2(N);
    localparam int LB_LEN = (K - 1) * N;
    localparam int P_W    = D_WIDTH + W_WIDTH + 1;
    localparam int ACC_W  = P_W + $clog2(NT);

    localparam logic signed [ACC_W-1:0]   ACC_MAX  = {{(ACC_W-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]   ACC_MIN  = {{(ACC_W-Q_WIDTH+1){1'b1}}, {(Q_WIDTH-1){1'b0}}};
    localparam logic signed [Q_WIDTH-1:0] SAT_HI   = {1'b0, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [Q_WIDTH-1:0] SAT_LO   = {1'b1, {(Q_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]             LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0]             FULL_IDX = CW'(K - 1);

    logic [CW-1:0]             row_q, row_d, col_q, col_d;
    logic [D_WIDTH-1:0]        lb_q   [D_CHANNELS][LB_LEN];
    logic [D_WIDTH-1:0]        lb_d   [D_CHANNELS][LB_LEN];
    logic [D_WIDTH-1:0]        win_q  [D_CHANNELS][K][K];
    logic [D_WIDTH-1:0]        win_d  [D_CHANNELS][K][K];
    logic signed [W_WIDTH-1:0] wt_q   [NT];
    logic signed [W_WIDTH-1:0] wt_d   [NT];
    logic signed [P_W-1:0]     prod_q [NT];
    logic signed [P_W-1:0]     prod_d [NT];
    logic                      prod_vld_q, prod_vld_d, prod_last_q, prod_last_d;
    logic signed [Q_WIDTH-1:0] sum_q, sum_d;
    logic                      sum_vld_q, sum_vld_d, sum_last_q, sum_last_d;
    logic signed [Q_WIDTH-1:0] out_q, out_d;
    logic                      valid_q, valid_d, last_q, last_d;

    logic                      pix_acc;
    logic signed [P_W-1:0]     px_ext, wt_ext;
    logic signed [ACC_W-1:0]   acc;

    assign pix_acc = clk_en & in_valid;

    // Window column K-1 is the newest pixel; older rows come from the line-buffer taps N, 2N, ... pixels back.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        lb_d  = lb_q;
        win_d = win_q;
        if (pix_acc) begin
            for (int ch = 0; ch < D_CHANNELS; ch++) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_d[ch][r][c] = win_q[ch][r][c+1];
                    end
                end
                for (int r = 0; r < K - 1; r++) begin
                    win_d[ch][r][K-1] = lb_q[ch][(K-1-r)*N-1];
                end
                win_d[ch][K-1][K-1] = input_data[ch*D_WIDTH +: D_WIDTH];
                for (int i = LB_LEN - 1; i > 0; i--) begin
                    lb_d[ch][i] = lb_q[ch][i-1];
                end
                lb_d[ch][0] = input_data[ch*D_WIDTH +: D_WIDTH];
            end
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        wt_d = wt_q;
        if (clk_en && w_wr_en && (32'(w_addr) < NT)) begin
            wt_d[w_addr] = w_data;
        end
    end

    // Products are taken from the incoming window against the pre-write weights, so a
    // write on the acceptance edge only affects later pixels.
    always_comb begin
        prod_d      = prod_q;
        prod_vld_d  = prod_vld_q;
        prod_last_d = prod_last_q;
        sum_d       = sum_q;
        sum_vld_d   = sum_vld_q;
        sum_last_d  = sum_last_q;
        out_d       = out_q;
        valid_d     = valid_q;
        last_d      = last_q;
        px_ext      = '0;
        wt_ext      = '0;
        acc         = '0;
        if (clk_en) begin
            for (int ch = 0; ch < D_CHANNELS; ch++) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        px_ext = P_W'(win_d[ch][r][c]);
                        wt_ext = P_W'(wt_q[ch*K*K + r*K + c]);
                        prod_d[ch*K*K + r*K + c] = px_ext * wt_ext;
                    end
                end
            end
            prod_vld_d  = pix_acc && (row_q >= FULL_IDX) && (col_q >= FULL_IDX);
            prod_last_d = pix_acc && (row_q == LAST_IDX) && (col_q == LAST_IDX);

            for (int i = 0; i < NT; i++) begin
                acc = acc + ACC_W'(prod_q[i]);
            end
            if (acc > ACC_MAX) begin
                sum_d = SAT_HI;
            end else if (acc < ACC_MIN) begin
                sum_d = SAT_LO;
            end else begin
                sum_d = acc[Q_WIDTH-1:0];
            end
            sum_vld_d  = prod_vld_q;
            sum_last_d = prod_last_q;

            valid_d = sum_vld_q;
            last_d  = sum_vld_q && sum_last_q;
            if (sum_vld_q) begin
                out_d = sum_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            for (int ch = 0; ch < D_CHANNELS; ch++) begin
                for (int i = 0; i < LB_LEN; i++) begin
                    lb_q[ch][i] <= '0;
                end
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        win_q[ch][r][c] <= '0;
                    end
                end
            end
            for (int i = 0; i < NT; i++) begin
                wt_q[i]   <= W_WIDTH'(1);
                prod_q[i] <= '0;
            end
            prod_vld_q  <= 1'b0;
            prod_last_q <= 1'b0;
            sum_q       <= '0;
            sum_vld_q   <= 1'b0;
            sum_last_q  <= 1'b0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            lb_q        <= lb_d;
            win_q       <= win_d;
            wt_q        <= wt_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            prod_last_q <= prod_last_d;
            sum_q       <= sum_d;
            sum_vld_q   <= sum_vld_d;
            sum_last_q  <= sum_last_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    assign output_data = out_q;
    assign valid       = valid_q;
    assign last        = last_q;

endmodule

// File: tb/tb_conv_window_accumulator.sv
// Directed bench for conv_window_accumulator on a 4x4 image, 2x2 kernel, two channels.
module tb_conv_window_accumulator;
    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic               in_valid;
    logic [15:0]        input_data;
    logic               w_wr_en;
    logic [2:0]         w_addr;
    logic signed [7:0]  w_data;
    logic signed [15:0] output_data;
    logic               valid;
    logic               last;

    int          checks = 0;
    int          errors = 0;
    int          got_q[$];
    int          last_cnt;
    int          last_pos;
    int          step;
    logic [31:0] vmask;

    // Box filter on raster ch0: window at (y,x) sums to 16y + 4x - 10.
    int e_box[9] = '{10, 14, 18, 26, 30, 34, 42, 46, 50};
    int e_ch1[9] = '{22, 26, 30, 38, 42, 46, 54, 58, 62};
    int e_w0[9]  = '{0, -2, -4, -8, -10, -12, -16, -18, -20};
    int e_hi[9];
    int e_lo[9];

    conv_window_accumulator #(
        .D_WIDTH(8), .W_WIDTH(8), .Q_WIDTH(16),
        .D_CHANNELS(2), .FILTER_SIZE(2), .IMAGE_SIZE(N)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid),
        .input_data(input_data), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
        .output_data(output_data), .valid(valid), .last(last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic iv, input logic [7:0] p0, input logic [7:0] p1);
        clk_en     = en;
        in_valid   = iv;
        input_data = {p1, p0};
        @(posedge clk);
        #1;
        if (en) begin
            if (step < 32) vmask[step] = valid;
            step++;
            if (last === 1'b1 && valid !== 1'b1) last_cnt += 100;
            if (valid === 1'b1) begin
                got_q.push_back(int'(output_data));
                if (last === 1'b1) begin
                    last_cnt++;
                    last_pos = got_q.size() - 1;
                end
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic signed [7:0] d);
        w_wr_en = 1'b1;
        w_addr  = a;
        w_data  = d;
        cyc(1'b1, 1'b0, 8'd0, 8'd0);
        w_wr_en = 1'b0;
    endtask

    // c0 < 0 streams the raster index on ch0, otherwise a constant.
    task automatic frame(input int c0, input int c1, input bit gaps);
        got_q.delete();
        last_cnt = 0;
        last_pos = -1;
        step     = 0;
        vmask    = '0;
        for (int i = 0; i < 16; i++) begin
            if (gaps && i == 8) begin
                for (int s = 0; s < 3; s++) begin
                    cyc(1'b0, 1'b1, 8'hAA, 8'h55);
                    chk("hold_data", output_data, 10);
                    chk("hold_valid", valid, 1);
                end
                cyc(1'b1, 1'b0, 8'd0, 8'd0);
            end
            if (gaps && i == 11) begin
                cyc(1'b1, 1'b0, 8'd0, 8'd0);
                cyc(1'b0, 1'b1, 8'hAA, 8'h55);
            end
            if (gaps && i == 14) begin
                cyc(1'b0, 1'b0, 8'd0, 8'd0);
                cyc(1'b1, 1'b0, 8'd0, 8'd0);
                cyc(1'b1, 1'b0, 8'd0, 8'd0);
            end
            cyc(1'b1, 1'b1, (c0 < 0) ? 8'(i) : 8'(c0), 8'(c1));
        end
        cyc(1'b1, 1'b0, 8'd0, 8'd0);
        cyc(1'b1, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic cmp_frame(input string tag, input int e[9]);
        chk($sformatf("%s_count", tag), got_q.size(), 9);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s_val%0d", tag, k), (k < got_q.size()) ? got_q[k] : -99999, e[k]);
        end
        chk($sformatf("%s_last_cnt", tag), last_cnt, 1);
        chk($sformatf("%s_last_pos", tag), last_pos, 8);
    endtask

    initial begin
        rst        = 1'b1;
        clk_en     = 1'b1;
        in_valid   = 1'b0;
        input_data = '0;
        w_wr_en    = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        step       = 0;
        vmask      = '0;
        last_cnt   = 0;
        last_pos   = -1;
        for (int k = 0; k < 9; k++) begin
            e_hi[k] = 32767;
            e_lo[k] = -32768;
        end

        cyc(1'b1, 1'b0, 8'd0, 8'd0);
        cyc(1'b1, 1'b0, 8'd0, 8'd0);
        rst = 1'b0;
        chk("rst_data", output_data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);

        // Weight write while disabled must be dropped.
        w_wr_en = 1'b1;
        w_addr  = 3'd1;
        w_data  = 8'sd0;
        cyc(1'b0, 1'b0, 8'd0, 8'd0);
        w_wr_en = 1'b0;

        frame(-1, 0, 1'b0);
        chk("box_vmask", 32'(vmask[17:0]), 32'h3BB80);
        cmp_frame("box", e_box);

        frame(-1, 3, 1'b0);
        cmp_frame("ch1", e_ch1);

        frame(-1, 0, 1'b1);
        cmp_frame("gaps", e_box);

        wr(3'd0, 8'(-2));
        for (int a = 1; a < 8; a++) wr(3'(a), 8'(0));
        frame(-1, 0, 1'b0);
        cmp_frame("w0", e_w0);

        for (int a = 0; a < 8; a++) wr(3'(a), 8'(127));
        frame(255, 255, 1'b0);
        cmp_frame("sat_hi", e_hi);

        for (int a = 0; a < 8; a++) wr(3'(a), 8'(-128));
        frame(255, 255, 1'b0);
        cmp_frame("sat_lo", e_lo);

        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'(i), 8'd0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'hFF, 8'hFF);
        rst = 1'b0;
        chk("midrst_valid", valid, 0);
        chk("midrst_data", output_data, 0);
        chk("midrst_last", last, 0);
        frame(-1, 0, 1'b0);
        chk("midrst_vmask", 32'(vmask[17:0]), 32'h3BB80);
        cmp_frame("midrst", e_box);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
